// File: rtl/myproject_dense_accum.sv
// ---------------------------------------------------------------------------
// myproject_dense_accum
//
// Purpose:
//   Accumulates N_IN signed products from an upstream multiplier into one
//   dense-layer output. The first product of a frame also loads the bias,
//   which is pre-scaled into accumulator units. The finished sum is shifted
//   down by FRAC_SHIFT, which floors toward negative infinity. It is then
//   saturated to 16 bits and presented with a valid/ready handshake.
//
// Ports:
//   ap_clk     in   1   clock, rising edge
//   ap_rst     in   1   synchronous active-high reset
//   prod_data  in  23   signed product
//   prod_valid in   1   prod_data is valid
//   prod_ready out  1   block can accept a product (IDLE/ACCUM only)
//   bias       in  16   signed bias, sampled on the first product of a frame
//   out_data   out 16   signed saturated result
//   out_valid  out  1   out_data is valid (DONE only)
//   out_ready  in   1   downstream accepts the result
//   out_sat    out  1   current result was clipped
// ---------------------------------------------------------------------------
module myproject_dense_accum #(
  parameter int N_IN       = 16,
  parameter int FRAC_SHIFT = 6,
  parameter int ACC_WIDTH  = 40
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [22:0] prod_data,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [15:0] bias,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sat
);

  localparam int CNT_W = $clog2(N_IN + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_IN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                  r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]            r_cnt;
  logic [15:0]                 r_out_data;
  logic                        r_out_sat;

  logic                        w_xfer;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic [ACC_WIDTH-16:0]       w_hi;
  logic                        w_ovf;
  logic [15:0]                 w_sat_data;

  // Handshake outputs depend on state alone, so prod_ready never sees out_ready.
  assign prod_ready = (r_state != S_DONE);
  assign out_valid  = (r_state == S_DONE);
  assign out_data   = r_out_data;
  assign out_sat    = r_out_sat;

  assign w_xfer     = prod_valid & prod_ready;
  assign w_prod_ext = {{(ACC_WIDTH-23){prod_data[22]}}, prod_data};
  assign w_bias_ext = {{(ACC_WIDTH-16){bias[15]}}, bias};

  // The transfer that completes the frame: either the only product (N_IN == 1)
  // or the one arriving when N_IN-1 products have already been summed.
  assign w_last = w_xfer &
                  (((r_state == S_IDLE) && (N_IN == 1)) ||
                   ((r_state == S_ACCUM) && (r_cnt == C_LAST)));

  // The first product of a frame replaces the old sum with the scaled bias
  // instead of adding to it. This is what makes bias sampling frame-local.
  always_comb begin
    w_acc_next = r_acc + w_prod_ext;
    if (r_state == S_IDLE) begin
      w_acc_next = (w_bias_ext <<< FRAC_SHIFT) + w_prod_ext;
    end
  end

  // The arithmetic shift floors toward negative infinity. The result fits in
  // 16 bits only when every bit from 15 upward equals the sign bit.
  assign w_shifted  = w_acc_next >>> FRAC_SHIFT;
  assign w_hi       = w_shifted[ACC_WIDTH-1:15];
  assign w_ovf      = !((&w_hi) || !(|w_hi));
  assign w_sat_data = w_ovf ? (w_shifted[ACC_WIDTH-1] ? 16'h8000 : 16'h7FFF)
                            : w_shifted[15:0];

  // Frame control: IDLE waits for the first product, ACCUM sums the rest,
  // and DONE holds the result until downstream takes it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_acc   <= w_acc_next;
            r_cnt   <= CNT_W'(1);
            r_state <= w_last ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The result is captured on the last transfer itself, so it is already
  // stable in the first DONE cycle. It stays held until the next frame ends.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_last) begin
      r_out_data <= w_sat_data;
      r_out_sat  <= w_ovf;
    end
  end

endmodule

// File: tb/tb_myproject_dense_accum.sv
// ---------------------------------------------------------------------------
// tb_myproject_dense_accum
//
// Purpose:
//   Runs directed frames through myproject_dense_accum with N_IN=4 and
//   FRAC_SHIFT=6. Each frame has a hand-computed expected result.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_myproject_dense_accum;

  logic               ap_clk;
  logic               ap_rst;
  logic        [22:0] prod_data;
  logic               prod_valid;
  logic               prod_ready;
  logic        [15:0] bias;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sat;

  int testCount;
  int failCount;

  myproject_dense_accum #(
    .N_IN      (4),
    .FRAC_SHIFT(6),
    .ACC_WIDTH (40)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // One comparison: count it, and report a failure on mismatch.
  task automatic check(input string tag, input int observed, input int expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Offer one product and hold it until it is accepted, with a bounded wait.
  task automatic applyStimulus(input int value);
    int waitCycles;
    prod_data  = 23'(value);
    prod_valid = 1'b1;
    waitCycles = 0;
    while (!prod_ready && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!prod_ready) begin
      check("prod_ready_timeout", 0, 1);
    end
    tick();
    prod_valid = 1'b0;
  endtask

  // Idle cycles with no product offered.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Check a finished result, accept it, and confirm the return to IDLE.
  task automatic checkOutput(input string tag, input int expData, input int expSat);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"}, int'(out_data), expData);
    check({tag, "_sat"}, int'(out_sat), expSat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_ready_back"}, int'(prod_ready), 1);
  endtask

  initial begin
    testCount  = 0;
    failCount  = 0;
    ap_rst     = 1'b1;
    prod_data  = '0;
    prod_valid = 1'b0;
    bias       = '0;
    out_ready  = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    ap_rst = 1'b0;
    tick();
    check("rst_prod_ready", int'(prod_ready), 1);

    // Basic frame: (64+128+192+256) >> 6 = 10.
    bias = 16'sd0;
    applyStimulus(64);
    applyStimulus(128);
    applyStimulus(192);
    applyStimulus(256);
    checkOutput("basic", 10, 0);

    // Bias 1 gives (64-4) >> 6 = 0. Later bias changes must be ignored.
    bias = 16'sd1;
    applyStimulus(-1);
    bias = 16'sd100;
    applyStimulus(-1);
    applyStimulus(-1);
    applyStimulus(-1);
    checkOutput("bias1", 0, 0);

    // Bias 0 gives -4 >> 6, which floors to -1.
    bias = 16'sd0;
    for (int i = 0; i < 4; i++) applyStimulus(-1);
    checkOutput("floor", -1, 0);

    // Positive saturation: 4*4194303 >> 6 = 262143, clipped to 32767.
    for (int i = 0; i < 4; i++) applyStimulus(4194303);
    checkOutput("sat_pos", 32767, 1);

    // Negative saturation: 4*-4194304 >> 6 = -262144, clipped to -32768.
    for (int i = 0; i < 4; i++) applyStimulus(-4194304);
    checkOutput("sat_neg", -32768, 1);

    // Backpressure: hold DONE for 5 cycles while a product is offered.
    applyStimulus(64);
    applyStimulus(128);
    applyStimulus(192);
    applyStimulus(256);
    prod_data  = 23'(1000);
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), 10);
      check("stall_ready", int'(prod_ready), 0);
      tick();
    end
    prod_valid = 1'b0;
    checkOutput("stall_release", 10, 0);

    // A clean frame after the stall confirms that no product leaked in.
    applyStimulus(64);
    applyStimulus(128);
    applyStimulus(192);
    applyStimulus(256);
    checkOutput("post_stall", 10, 0);

    // Bubbles between products, with bias wiggling in the gaps.
    bias = 16'sd0;
    applyStimulus(64);
    bias = 16'sd7;
    idle(1);
    applyStimulus(128);
    idle(3);
    applyStimulus(192);
    bias = -16'sd5;
    idle(2);
    check("bubble_no_early_valid", int'(out_valid), 0);
    applyStimulus(256);
    checkOutput("bubbles", 10, 0);

    // Reset in mid-frame discards the partial sum.
    bias = 16'sd0;
    applyStimulus(1000);
    applyStimulus(2000);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_data", int'(out_data), 0);
    check("midrst_ready", int'(prod_ready), 1);
    applyStimulus(64);
    applyStimulus(128);
    applyStimulus(192);
    applyStimulus(256);
    checkOutput("midrst_frame", 10, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
